// File: rtl/sram_like_master_pkg.sv
// Shared definitions for the sram-like bus initiator: FSM encoding and
// transfer-size codes.
package sram_like_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic is_write(input logic [3:0] wen);
    return |wen;
  endfunction

endpackage

// File: rtl/sram_like_master_if.sv
// Sram-like bus between an initiator (pipeline side) and a responder (cache).
interface sram_like_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  wr;
  logic [1:0]            size;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  addr_ok;
  logic                  data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_master.sv
// Turns one pipeline-stage access into one sram-like transaction, stalls the
// stage until it completes and holds the load result across external freezes.
module sram_like_master
  import sram_like_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_en,
  input  logic [3:0]            cpu_wen,
  input  logic [1:0]            cpu_size,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  cpu_flush,
  input  logic                  ext_stall,
  sram_like_master_if.master    bus
);

  state_e                state_q, state_d;
  logic                  discard_q, discard_d;
  logic [DATA_WIDTH-1:0] rdata_buf_q;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic access, issue, in_data, done_ok;

  assign access  = cpu_en & ~cpu_flush;
  assign issue   = (state_q == ST_IDLE) & access;
  assign in_data = (state_q == ST_DATA);
  assign done_ok = in_data & bus.data_ok;

  // A flushed access still drains to data_ok; only its result is dropped.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    case (state_q)
      ST_IDLE: if (issue) state_d = bus.addr_ok ? ST_DATA : ST_ADDR;
      ST_ADDR: begin
        if (cpu_flush)   discard_d = 1'b1;
        if (bus.addr_ok) state_d   = ST_DATA;
      end
      ST_DATA: begin
        if (cpu_flush) discard_d = 1'b1;
        if (bus.data_ok) begin
          discard_d = 1'b0;
          if (discard_q | cpu_flush) state_d = ST_IDLE;
          else if (ext_stall)        state_d = ST_DONE;
          else                       state_d = ST_IDLE;
        end
      end
      ST_DONE: if (cpu_flush | ~ext_stall) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      discard_q   <= 1'b0;
      rdata_buf_q <= '0;
      wr_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (done_ok) rdata_buf_q <= bus.rdata;
      if (issue) begin
        wr_q    <= is_write(cpu_wen);
        size_q  <= cpu_size;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
    end
  end

  // Outputs are forced low for the whole reset window, not just after the edge.
  assign bus.req = ~reset & (issue | (state_q == ST_ADDR));

  always_comb begin
    bus.wr    = 1'b0;
    bus.size  = SZ_BYTE;
    bus.addr  = '0;
    bus.wdata = '0;
    if (!reset) begin
      if (state_q == ST_IDLE) begin
        bus.wr    = is_write(cpu_wen);
        bus.size  = cpu_size;
        bus.addr  = cpu_addr;
        bus.wdata = cpu_wdata;
      end else begin
        bus.wr    = wr_q;
        bus.size  = size_q;
        bus.addr  = addr_q;
        bus.wdata = wdata_q;
      end
    end
  end

  assign cpu_rdata = reset   ? '0 :
                     done_ok ? bus.rdata : rdata_buf_q;

  // A new access behind a discarded one keeps stalling until the drain ends.
  assign cpu_stall = ~reset & access &
                     ((state_q == ST_IDLE) | (state_q == ST_ADDR) |
                      (in_data & (~bus.data_ok | discard_q)));

  a_data_ok_only_in_data: assert property (
    @(posedge clk) disable iff (reset) bus.data_ok |-> (state_q == ST_DATA));

  a_no_data_ok_with_accept: assert property (
    @(posedge clk) disable iff (reset) (bus.req & bus.addr_ok) |-> ~bus.data_ok);

endmodule

// File: tb/tb_sram_like_master.sv
// Directed plus random checks of the sram-like initiator against a
// transaction-level model of the access lifecycle.
module tb_sram_like_master;
  import sram_like_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          en, flush, xstall;
  logic [3:0]    wen;
  logic [1:0]    sz;
  logic [AW-1:0] caddr;
  logic [DW-1:0] cwdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  sram_like_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_like_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_en(en), .cpu_wen(wen), .cpu_size(sz), .cpu_addr(caddr),
    .cpu_wdata(cwdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_flush(flush), .ext_stall(xstall), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Access lifecycle: busy = issued and not yet answered, acc = address
  // accepted, drop = result will be thrown away, hold = answered while frozen.
  bit            m_busy, m_acc, m_drop, m_hold;
  logic          m_wr;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_buf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_idle();
    return !m_busy && !m_hold;
  endfunction

  function automatic bit exp_req();
    if (reset) return 1'b0;
    if (m_idle()) return en && !flush;
    return m_busy && !m_acc;
  endfunction

  function automatic bit exp_stall();
    if (reset || !en || flush || m_hold) return 1'b0;
    if (!m_busy || !m_acc) return 1'b1;
    return !bus.data_ok || m_drop;
  endfunction

  function automatic logic [DW-1:0] exp_rdata();
    if (reset) return '0;
    if (m_busy && m_acc && bus.data_ok) return bus.rdata;
    return m_buf;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_acc = 0; m_drop = 0; m_hold = 0;
    m_wr = 0; m_size = 0; m_addr = '0; m_wdata = '0; m_buf = '0;
  endtask

  task automatic check_outputs();
    bit r;
    r = exp_req();
    chk("req",   32'(bus.req),   32'(r));
    chk("stall", 32'(cpu_stall), 32'(exp_stall()));
    chk("rdata", cpu_rdata,      exp_rdata());
    if (r) begin
      chk("wr",    32'(bus.wr),   32'(m_idle() ? (|wen) : m_wr));
      chk("size",  32'(bus.size), 32'(m_idle() ? sz : m_size));
      chk("addr",  bus.addr,      m_idle() ? caddr : m_addr);
      chk("wdata", bus.wdata,     m_idle() ? cwdata : m_wdata);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      model_clear();
    end else if (m_idle()) begin
      if (en && !flush) begin
        m_busy = 1; m_acc = bus.addr_ok;
        m_wr = |wen; m_size = sz; m_addr = caddr; m_wdata = cwdata;
      end
    end else if (m_busy && !m_acc) begin
      if (flush) m_drop = 1;
      if (bus.addr_ok) m_acc = 1;
    end else if (m_busy) begin
      if (flush) m_drop = 1;
      if (bus.data_ok) begin
        m_buf  = bus.rdata;
        m_hold = !m_drop && xstall;
        m_busy = 0; m_acc = 0; m_drop = 0;
      end
    end else begin
      if (flush || !xstall) m_hold = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [1:0] s,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    en = e; wen = w; sz = s; caddr = a; cwdata = d;
  endtask

  task automatic bus_drv(input logic aok, input logic dok, input logic [DW-1:0] rd);
    bus.addr_ok = aok; bus.data_ok = dok; bus.rdata = rd;
  endtask

  initial begin
    logic [DW-1:0] v, vals [4];
    logic [AW-1:0] a_old;

    model_clear();
    reset = 1'b1; flush = 0; xstall = 0;
    drive(1, 4'hF, SZ_WORD, 32'h1234_5678, 32'hFFFF_FFFF);
    bus_drv(1, 0, 32'h5555_AAAA);
    #2;
    chk("rst_req",   32'(bus.req),   0);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_rdata", cpu_rdata,      0);
    chk("rst_wr",    32'(bus.wr),    0);
    chk("rst_addr",  bus.addr,       0);
    chk("rst_wdata", bus.wdata,      0);
    chk("rst_size",  32'(bus.size),  0);
    tick();
    reset = 1'b0;
    drive(0, 0, SZ_WORD, 0, 0); bus_drv(0, 0, 0);
    tick();

    // Read with immediate accept, one idle cycle in DATA.
    drive(1, 4'h0, SZ_WORD, 32'h1000_0004, 0); bus_drv(1, 0, 0);
    #1 chk("rd_req", 32'(bus.req), 1);
    tick();
    bus_drv(0, 0, 0);
    tick();
    bus_drv(0, 1, 32'hDEAD_BEEF);
    #1 chk("rd_bypass", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_release", 32'(cpu_stall), 0);
    tick();
    drive(0, 0, SZ_WORD, 0, 0); bus_drv(0, 0, 0);
    #1 chk("rd_hold", cpu_rdata, 32'hDEAD_BEEF);
    tick();

    // Write with addr_ok after three waiting cycles.
    drive(1, 4'hF, SZ_WORD, $urandom & 32'hFFFF_FFFC, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      bus_drv(k == 3, 0, 0);
      #1 chk("wr_wr", 32'(bus.wr), 1);
      chk("wr_wdata", bus.wdata, 32'h1234_5678);
      tick();
    end
    bus_drv(0, 0, 0);
    tick();
    bus_drv(0, 1, $urandom);
    #1 chk("wr_release", 32'(cpu_stall), 0);
    tick();
    drive(0, 0, SZ_WORD, 0, 0); bus_drv(0, 0, 0);
    #1 chk("wr_no_reissue", 32'(bus.req), 0);
    tick();

    // Read finishing under an external freeze.
    v = $urandom;
    drive(1, 0, SZ_HALF, 32'h0000_0102, 0); xstall = 1; bus_drv(1, 0, 0);
    tick();
    bus_drv(0, 1, v);
    tick();
    bus_drv(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("frz_stall", 32'(cpu_stall), 0);
      chk("frz_req", 32'(bus.req), 0);
      chk("frz_rdata", cpu_rdata, v);
      tick();
    end
    xstall = 0;
    tick();
    drive(0, 0, SZ_WORD, 0, 0);
    tick();

    // Flush while waiting for accept, then a new access behind the drain.
    a_old = $urandom;
    drive(1, 0, SZ_WORD, a_old, 0); bus_drv(0, 0, 0);
    tick();
    flush = 1;
    #1 chk("fl_req_held", 32'(bus.req), 1);
    tick();
    flush = 0; drive(1, 0, SZ_WORD, 32'h0000_2000, 0);
    #1 chk("fl_old_addr", bus.addr, a_old);
    tick();
    bus_drv(1, 0, 0);
    tick();
    bus_drv(0, 0, 0);
    tick();
    bus_drv(0, 1, $urandom);
    #1 chk("fl_drain_stall", 32'(cpu_stall), 1);
    tick();
    bus_drv(1, 0, 0);
    #1 chk("fl_new_req", 32'(bus.req), 1);
    chk("fl_new_addr", bus.addr, 32'h0000_2000);
    tick();
    bus_drv(0, 1, 32'hCAFE_F00D);
    #1 chk("fl_new_rdata", cpu_rdata, 32'hCAFE_F00D);
    tick();
    drive(0, 0, SZ_WORD, 0, 0); bus_drv(0, 0, 0);
    tick();

    // Reset while in DATA; a late data_ok during reset must be ignored.
    drive(1, 0, SZ_WORD, 32'h0000_0040, 0); bus_drv(1, 0, 0);
    tick();
    bus_drv(0, 0, 0);
    #2 reset = 1'b1;
    #1 chk("rstd_req", 32'(bus.req), 0);
    chk("rstd_stall", 32'(cpu_stall), 0);
    chk("rstd_rdata", cpu_rdata, 0);
    bus_drv(0, 1, 32'h7777_7777);
    tick();
    bus_drv(0, 0, 0); reset = 1'b0; drive(0, 0, SZ_WORD, 0, 0);
    #1 chk("rstd_late_ignored", cpu_rdata, 0);
    tick();

    // Four back-to-back loads against a 1-cycle responder.
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, SZ_WORD, 32'h3000_0000 + 32'(i * 4), 0); bus_drv(1, 0, 0);
      #1 chk("b2b_req", 32'(bus.req), 1);
      tick();
      bus_drv(0, 1, vals[i]);
      #1 chk("b2b_rdata", cpu_rdata, vals[i]);
      tick();
    end
    drive(0, 0, SZ_WORD, 0, 0); bus_drv(0, 0, 0);
    tick();

    // Random traffic: legal responder, random flushes and freezes.
    for (int c = 0; c < 600; c++) begin
      en     = ($urandom_range(0, 9) < 7);
      wen    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      sz     = 2'($urandom_range(0, 2));
      caddr  = $urandom;
      cwdata = $urandom;
      flush  = ($urandom_range(0, 9) == 0);
      xstall = ($urandom_range(0, 3) == 0);
      bus.addr_ok = exp_req() && ($urandom_range(0, 1) == 1);
      bus.data_ok = m_busy && m_acc && ($urandom_range(0, 4) < 2);
      bus.rdata   = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
